// File: rtl/i2c_slave_read_pkg.sv
// Shared types and constants for the I2C slave receive path.
// The write path imports the same package.
package i2c_slave_read_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = $clog2(BYTE_W);

    typedef enum logic [1:0] {
        I2C_RD_IDLE = 2'd0,
        I2C_RD_RECV = 2'd1,
        I2C_RD_DONE = 2'd2,
        I2C_RD_ERR  = 2'd3
    } rd_state_e;

    // True when cnt addresses the final bit of the current transfer.
    function automatic logic last_bit(input logic [CNT_W-1:0] cnt, input logic is_byte);
        return is_byte ? (cnt == CNT_W'(BYTE_W - 1)) : (cnt == '0);
    endfunction

endpackage

// File: rtl/i2c_slave_read_if.sv
// Controller-facing port bundle of the I2C slave receive path.
interface i2c_slave_read_if;
    import i2c_slave_read_pkg::*;

    logic              rd_en;
    logic              is_byte;
    logic              scl_i;
    logic              sda_i;
    logic [BYTE_W-1:0] data_o;
    logic              rd_finish;
    logic              get_start;
    logic              get_stop;
    logic              bus_err;

    modport master (
        output rd_en, is_byte, scl_i, sda_i,
        input  data_o, rd_finish, get_start, get_stop, bus_err
    );

    modport slave (
        input  rd_en, is_byte, scl_i, sda_i,
        output data_o, rd_finish, get_start, get_stop, bus_err
    );

endinterface

// File: rtl/i2c_bus_monitor.sv
// SCL edge and START/STOP detection on already-synchronized SCL/SDA.
// All detections are gated by en.
module i2c_bus_monitor (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic get_start,
    output logic get_stop
);

    logic scl_last;
    logic sda_last;

    // Previous-sample registers idle high like the bus itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_last <= 1'b1;
            sda_last <= 1'b1;
        end else begin
            scl_last <= scl;
            sda_last <= sda;
        end
    end

    assign scl_rise  = en & ~scl_last &  scl;
    assign scl_fall  = en &  scl_last & ~scl;

    // SCL must be high on both samples so an SDA move at an SCL edge is not a condition.
    assign get_start = en & scl_last & scl &  sda_last & ~sda;
    assign get_stop  = en & scl_last & scl & ~sda_last &  sda;

endmodule

// File: rtl/i2c_slave_read.sv
// I2C slave receive path: assembles one ACK bit or an MSB-first byte from SDA,
// reports START/STOP and flags START/STOP arriving mid-transfer.
module i2c_slave_read
    import i2c_slave_read_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    i2c_slave_read_if.slave   bus
);

    logic scl_rise;
    logic scl_fall;
    logic get_start;
    logic get_stop;

    rd_state_e         state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              sampled_q, sampled_d;
    logic              bit_q,     bit_d;
    logic [BYTE_W-1:0] shift_q,   shift_d;
    logic [BYTE_W-1:0] data_q,    data_d;
    logic              finish_q,  finish_d;
    logic              err_q,     err_d;

    i2c_bus_monitor u_mon (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (bus.rd_en),
        .scl       (bus.scl_i),
        .sda       (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .get_start (get_start),
        .get_stop  (get_stop)
    );

    assign bus.get_start = get_start;
    assign bus.get_stop  = get_stop;
    assign bus.data_o    = data_q;
    assign bus.rd_finish = finish_q;
    assign bus.bus_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= I2C_RD_IDLE;
            cnt_q     <= '0;
            sampled_q <= 1'b0;
            bit_q     <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            finish_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sampled_q <= sampled_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            finish_q  <= finish_d;
            err_q     <= err_d;
        end
    end

    // Bits are captured on SCL rise and committed on the following fall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sampled_d = sampled_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        finish_d  = finish_q;
        err_d     = err_q;

        if (!bus.rd_en) begin
            state_d   = I2C_RD_IDLE;
            cnt_d     = '0;
            sampled_d = 1'b0;
            shift_d   = '0;
            finish_d  = 1'b0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                I2C_RD_IDLE: begin
                    state_d   = I2C_RD_RECV;
                    cnt_d     = '0;
                    sampled_d = 1'b0;
                    shift_d   = '0;
                    finish_d  = 1'b0;
                    err_d     = 1'b0;
                end
                I2C_RD_RECV: begin
                    if (get_start | get_stop) begin
                        state_d   = I2C_RD_ERR;
                        err_d     = 1'b1;
                        sampled_d = 1'b0;
                    end else if (scl_rise) begin
                        bit_d     = bus.sda_i;
                        sampled_d = 1'b1;
                    end else if (scl_fall && sampled_q) begin
                        // A fall without a prior rise means SCL was already high at enable.
                        shift_d   = {shift_q[BYTE_W-2:0], bit_q};
                        sampled_d = 1'b0;
                        if (last_bit(cnt_q, bus.is_byte)) begin
                            state_d  = I2C_RD_DONE;
                            data_d   = bus.is_byte ? {shift_q[BYTE_W-2:0], bit_q}
                                                   : BYTE_W'(bit_q);
                            finish_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                I2C_RD_DONE: begin
                    state_d = I2C_RD_DONE;
                end
                I2C_RD_ERR: begin
                    state_d = I2C_RD_ERR;
                end
                default: begin
                    state_d = I2C_RD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_read.sv
// Bench for i2c_slave_read: directed scenarios plus randomized transfers,
// completions and bus errors checked by a scoreboard monitor.
module tb_i2c_slave_read;

    logic clk;
    logic rst_n;

    i2c_slave_read_if bus ();

    i2c_slave_read dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         total;
    int         bad;
    int         gs_cnt;
    int         gp_cnt;
    logic [7:0] last_data;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Clock out n bits of v (MSB of the n-bit field first); SCL ends low.
    task automatic send_bits(input logic [7:0] v, input int n, input logic expect_done);
        for (int i = 0; i < n; i++) begin
            bus.sda_i = v[n-1-i];
            tick(3);
            bus.scl_i = 1'b1;
            tick(4);
            if (expect_done && i == n - 1) chk("finish_early", 8'(bus.rd_finish), 8'h00);
            bus.scl_i = 1'b0;
            tick(1);
            if (expect_done && i == n - 1) chk("finish_latency", 8'(bus.rd_finish), 8'h01);
            tick(2);
        end
    endtask

    // Reference: a byte transfer yields the byte, a bit transfer yields {7'b0, bit}.
    task automatic start_xfer(input logic byte_mode, input logic [7:0] v);
        exp_t e;
        e.is_err     = 1'b0;
        e.data       = byte_mode ? v : {7'b0, v[0]};
        sb_q.push_back(e);
        last_data    = e.data;
        bus.is_byte  = byte_mode;
        bus.rd_en    = 1'b1;
        tick(2);
        send_bits(v, byte_mode ? 8 : 1, 1'b1);
    endtask

    task automatic end_xfer();
        tick(2);
        bus.rd_en = 1'b0;
        tick(1);
        chk("finish_clr", 8'(bus.rd_finish), 8'h00);
        chk("err_clr", 8'(bus.bus_err), 8'h00);
        tick(2);
    endtask

    // k full bits, then SCL high with SDA = hi and an SDA toggle: START if hi=1, STOP if hi=0.
    task automatic err_xfer(input logic [7:0] v, input int k, input logic hi);
        exp_t e;
        int   gs0;
        int   gp0;
        e.is_err    = 1'b1;
        e.data      = last_data;
        sb_q.push_back(e);
        bus.is_byte = 1'b1;
        bus.rd_en   = 1'b1;
        tick(2);
        send_bits(v, k, 1'b0);
        bus.sda_i = hi;
        tick(3);
        bus.scl_i = 1'b1;
        tick(3);
        gs0 = gs_cnt;
        gp0 = gp_cnt;
        bus.sda_i = ~hi;
        tick(3);
        chk("cond_pulse", 8'((gs_cnt - gs0) + 2 * (gp_cnt - gp0)), hi ? 8'd1 : 8'd2);
        chk("err_no_finish", 8'(bus.rd_finish), 8'h00);
        chk("err_data_hold", bus.data_o, last_data);
        bus.scl_i = 1'b0;
        tick(2);
        end_xfer();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total       = 0;
        bad         = 0;
        gs_cnt      = 0;
        gp_cnt      = 0;
        last_data   = 8'h00;
        rst_n       = 1'b0;
        bus.rd_en   = 1'b0;
        bus.is_byte = 1'b1;
        bus.scl_i   = 1'b1;
        bus.sda_i   = 1'b1;
        fork
            begin : monitor
                logic fin_prev;
                logic err_prev;
                exp_t e;
                fin_prev = 1'b0;
                err_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (bus.get_start) gs_cnt++;
                        if (bus.get_stop)  gp_cnt++;
                        if ((bus.rd_finish && !fin_prev) || (bus.bus_err && !err_prev)) begin
                            total++;
                            if (sb_q.size() == 0) begin
                                bad++;
                                $display("FAIL sb_unexpected: got fin=%b err=%b data=%h expected nothing",
                                         bus.rd_finish, bus.bus_err, bus.data_o);
                            end else begin
                                e = sb_q.pop_front();
                                if (bus.bus_err !== e.is_err || bus.rd_finish !== !e.is_err ||
                                    bus.data_o !== e.data) begin
                                    bad++;
                                    $display("FAIL sb_event: got err=%b fin=%b data=%h expected err=%b data=%h",
                                             bus.bus_err, bus.rd_finish, bus.data_o, e.is_err, e.data);
                                end
                            end
                        end
                        fin_prev = bus.rd_finish;
                        err_prev = bus.bus_err;
                    end
                end
            end
            begin : stimulus
                tick(3);
                rst_n = 1'b1;
                tick(1);
                chk("rst_data", bus.data_o, 8'h00);
                chk("rst_finish", 8'(bus.rd_finish), 8'h00);
                chk("rst_err", 8'(bus.bus_err), 8'h00);

                // SDA toggles with SCL high while disabled: no condition reported.
                bus.sda_i = 1'b0;
                tick(2);
                bus.sda_i = 1'b1;
                tick(2);
                chk("disabled_cond", 8'(gs_cnt + gp_cnt), 8'd0);
                bus.scl_i = 1'b0;
                tick(3);

                start_xfer(1'b1, 8'hA5);
                chk("a5_no_err", 8'(bus.bus_err), 8'h00);
                end_xfer();

                start_xfer(1'b0, 8'h01);
                end_xfer();
                start_xfer(1'b0, 8'h00);
                end_xfer();

                // START after three 1-bits of 0xFF.
                err_xfer(8'hFF, 3, 1'b1);

                // Drop enable after 4 bits, then a clean byte.
                bus.is_byte = 1'b1;
                bus.rd_en   = 1'b1;
                tick(2);
                send_bits(8'h0F, 4, 1'b0);
                bus.rd_en = 1'b0;
                tick(1);
                chk("abort_finish", 8'(bus.rd_finish), 8'h00);
                tick(2);
                start_xfer(1'b1, 8'h3C);
                end_xfer();

                // Enable while SCL is high: the first fall carries no bit.
                bus.scl_i = 1'b1;
                tick(3);
                begin
                    exp_t e;
                    e.is_err  = 1'b0;
                    e.data    = 8'h81;
                    sb_q.push_back(e);
                    last_data = 8'h81;
                end
                bus.is_byte = 1'b1;
                bus.rd_en   = 1'b1;
                tick(3);
                bus.scl_i = 1'b0;
                tick(3);
                send_bits(8'h81, 8, 1'b1);
                end_xfer();

                // STOP while DONE.
                start_xfer(1'b1, 8'h5A);
                bus.sda_i = 1'b0;
                tick(3);
                bus.scl_i = 1'b1;
                tick(3);
                begin
                    int gp0;
                    gp0 = gp_cnt;
                    bus.sda_i = 1'b1;
                    tick(2);
                    chk("done_stop_pulse", 8'(gp_cnt - gp0), 8'd1);
                end
                chk("done_stop_err", 8'(bus.bus_err), 8'h00);
                chk("done_stop_fin", 8'(bus.rd_finish), 8'h01);
                bus.scl_i = 1'b0;
                tick(2);
                end_xfer();

                for (int t = 0; t < 24; t++) begin
                    int         sel;
                    logic [7:0] v;
                    sel = int'($urandom_range(0, 9));
                    v   = 8'($urandom);
                    if (sel < 5) begin
                        start_xfer(1'b1, v);
                        end_xfer();
                    end else if (sel < 7) begin
                        start_xfer(1'b0, v);
                        end_xfer();
                    end else if (sel < 8) begin
                        bus.is_byte = 1'b1;
                        bus.rd_en   = 1'b1;
                        tick(2);
                        send_bits(v, int'($urandom_range(1, 7)), 1'b0);
                        end_xfer();
                    end else begin
                        err_xfer(v, int'($urandom_range(0, 7)), 1'($urandom));
                    end
                end

                tick(5);
                chk("sb_empty", 8'(sb_q.size()), 8'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end

endmodule
